// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon-style game blocks.
//  NUM_LEDS  : number of LEDs / colour codes that light an LED
//  COLOR_W   : width of one pattern-memory entry
//  LEVEL_W   : width of level values and pattern-memory addresses
//  MAX_LEVEL : highest playable level; larger requests are clamped
//  blink_state_t : playback FSM states for seq_blinker
package simon_pkg;

    localparam int NUM_LEDS  = 4;
    localparam int COLOR_W   = 2;
    localparam int LEVEL_W   = 4;
    localparam int MAX_LEVEL = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_ON    = 3'd3,
        ST_OFF   = 3'd4,
        ST_DONE  = 3'd5
    } blink_state_t;

    // Counter width able to hold the longer interval minus one; never below 1 bit.
    function automatic int timer_width(input int on_cycles, input int off_cycles);
        int longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter shared by the ON and OFF intervals of seq_blinker.
//  clk   in  : system clock
//  reset in  : asynchronous active-low reset (count clears to 0)
//  load  in  : load 'value' on the next edge (takes priority over counting)
//  value in  : W-bit reload value (interval length minus one)
//  zero  out : registered flag, high while the count is 0
// The counter stops at 0 rather than wrapping, so a stale count is harmless.
module blink_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count_r;
    logic [W-1:0] count_nxt_s;
    logic         zero_r;

    // Next count: reload, otherwise decrement and hold at zero.
    always_comb begin
        count_nxt_s = count_r;
        if (load) begin
            count_nxt_s = value;
        end else if (count_r != {W{1'b0}}) begin
            count_nxt_s = count_r - W'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register with a registered zero flag derived from the next count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
            zero_r  <= 1'b1;
        end else begin
            count_r <= count_nxt_s;
            zero_r  <= (count_nxt_s == {W{1'b0}});
        end
    end

    assign zero = zero_r;

endmodule

// File: rtl/seq_blinker.sv
// Plays the stored colour sequence back on the LEDs, one LED per memory entry.
//  clk          in  : system clock
//  reset        in  : asynchronous active-low reset
//  on_blinker   in  : enable from the game FSM, high for the whole blink phase
//  level        in  : number of entries to play, sampled at start, clamped to MAX_LEVEL
//  mem_addr     out : pattern memory read address (data returns one clock later)
//  mem_data     in  : pattern memory read data (colour code)
//  leds         out : one-hot LED drive, zero when dark
//  blinker_done out : sequence finished, held while on_blinker stays high
// Each entry costs FETCH + LATCH + ON_CYCLES + OFF_CYCLES clocks. Dropping
// on_blinker anywhere outside IDLE abandons the sequence on the next edge.
module seq_blinker
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                on_blinker,
    input  logic [LEVEL_W-1:0]  level,
    output logic [LEVEL_W-1:0]  mem_addr,
    input  logic [COLOR_W-1:0]  mem_data,
    output logic [NUM_LEDS-1:0] leds,
    output logic                blinker_done
);

    localparam int                   TIMER_W   = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TIMER_W-1:0]   ON_LOAD   = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   OFF_LOAD  = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [LEVEL_W-1:0]   LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

    // Colour code to one-hot LED pattern; codes with no LED give all zeros.
    function automatic logic [NUM_LEDS-1:0] color_onehot(input logic [COLOR_W-1:0] color);
        logic [NUM_LEDS-1:0] onehot;
        onehot = {NUM_LEDS{1'b0}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (color == COLOR_W'(i)) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
        return onehot;
    endfunction

    blink_state_t        state_r,  state_nxt_s;
    logic [LEVEL_W-1:0]  idx_r,    idx_nxt_s;
    logic [LEVEL_W-1:0]  len_r,    len_nxt_s;
    logic [COLOR_W-1:0]  color_r,  color_nxt_s;
    logic [LEVEL_W-1:0]  addr_r,   addr_nxt_s;
    logic [NUM_LEDS-1:0] leds_r,   leds_nxt_s;
    logic                done_r,   done_nxt_s;

    logic [LEVEL_W-1:0]  clamped_s;
    logic [LEVEL_W-1:0]  idx_plus1_s;
    logic                tmr_load_s;
    logic [TIMER_W-1:0]  tmr_value_s;
    logic                tmr_zero_s;

    assign clamped_s   = (level > LEVEL_MAX) ? LEVEL_MAX : level;
    assign idx_plus1_s = idx_r + LEVEL_W'(1'b1);

    blink_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load_s),
        .value (tmr_value_s),
        .zero  (tmr_zero_s)
    );

    // Next-state and next-output logic; outputs are registered one edge later.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        len_nxt_s   = len_r;
        color_nxt_s = color_r;
        addr_nxt_s  = addr_r;
        leds_nxt_s  = {NUM_LEDS{1'b0}};
        done_nxt_s  = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_value_s = ON_LOAD;

        if ((state_r != ST_IDLE) && !on_blinker) begin
            // Abort: no partial done, LEDs go dark with the state change.
            state_nxt_s = ST_IDLE;
            addr_nxt_s  = {LEVEL_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    addr_nxt_s = {LEVEL_W{1'b0}};
                    if (on_blinker) begin
                        len_nxt_s = clamped_s;
                        idx_nxt_s = {LEVEL_W{1'b0}};
                        if (clamped_s == {LEVEL_W{1'b0}}) begin
                            state_nxt_s = ST_DONE;
                            done_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_FETCH;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    // Address was presented on entry; data arrives during LATCH.
                    state_nxt_s = ST_LATCH;
                end
                ST_LATCH: begin
                    color_nxt_s = mem_data;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = ON_LOAD;
                    leds_nxt_s  = color_onehot(mem_data);
                    state_nxt_s = ST_ON;
                end
                ST_ON: begin
                    if (tmr_zero_s) begin
                        tmr_load_s  = 1'b1;
                        tmr_value_s = OFF_LOAD;
                        state_nxt_s = ST_OFF;
                    end else begin
                        leds_nxt_s  = color_onehot(color_r);
                    end
                end
                ST_OFF: begin
                    if (tmr_zero_s) begin
                        if (idx_plus1_s == len_r) begin
                            state_nxt_s = ST_DONE;
                            done_nxt_s  = 1'b1;
                        end else begin
                            idx_nxt_s   = idx_plus1_s;
                            addr_nxt_s  = idx_plus1_s;
                            state_nxt_s = ST_FETCH;
                        end
                    end else begin
                        state_nxt_s = ST_OFF;
                    end
                end
                ST_DONE: begin
                    done_nxt_s = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    addr_nxt_s  = {LEVEL_W{1'b0}};
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sequence bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r   <= {LEVEL_W{1'b0}};
            len_r   <= {LEVEL_W{1'b0}};
            color_r <= {COLOR_W{1'b0}};
            addr_r  <= {LEVEL_W{1'b0}};
            leds_r  <= {NUM_LEDS{1'b0}};
            done_r  <= 1'b0;
        end else begin
            idx_r   <= idx_nxt_s;
            len_r   <= len_nxt_s;
            color_r <= color_nxt_s;
            addr_r  <= addr_nxt_s;
            leds_r  <= leds_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign mem_addr     = addr_r;
    assign leds         = leds_r;
    assign blinker_done = done_r;

endmodule

// File: tb/tb_seq_blinker.sv
// Self-checking bench for seq_blinker with ON_CYCLES=3, OFF_CYCLES=2.
// The reference model describes each played entry as a fixed-length slot of
// 2+ON+OFF edges and derives the expected LEDs, address and done flag from
// the edge count since the start edge.
module tb_seq_blinker;

    localparam int ON    = 3;
    localparam int OFF   = 2;
    localparam int PER   = 2 + ON + OFF;
    localparam int MAXLV = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       on_blinker;
    logic [3:0] level;
    logic [3:0] mem_addr;
    logic [1:0] mem_data;
    logic [3:0] leds;
    logic       blinker_done;

    logic [1:0] mem [16];

    int vectors     = 0;
    int miscompares = 0;

    seq_blinker #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .on_blinker   (on_blinker),
        .level        (level),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .leds         (leds),
        .blinker_done (blinker_done)
    );

    always #5 clk = ~clk;

    // Pattern memory with one clock of read latency.
    always @(posedge clk) begin
        mem_data <= mem[mem_addr];
    end

    // Expected LEDs k edges after the start edge for a sequence of len entries.
    function automatic logic [3:0] exp_leds(input int k, input int len);
        logic [3:0] v;
        int j;
        int r;
        v = 4'b0000;
        if (k < PER * len) begin
            j = k / PER;
            r = k % PER;
            if (r >= 2 && r < 2 + ON) v = 4'b0001 << mem[j];
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_addr(input int k, input int len);
        if (len == 0)          return 4'd0;
        else if (k >= PER*len) return 4'(len - 1);
        else                   return 4'(k / PER);
    endfunction

    function automatic logic exp_done(input int k, input int len);
        return (k >= PER * len);
    endfunction

    task automatic fill_fixed();
        for (int i = 0; i < 16; i++) mem[i] = 2'(i * 3 + 1);
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
    endtask

    // Start a sequence, scramble level afterwards, follow it to done and release.
    task automatic run_playback(input string tag, input int lvl);
        int len;
        len = (lvl > MAXLV) ? MAXLV : lvl;
        level = 4'(lvl);
        on_blinker = 1'b1;
        @(posedge clk); #1;
        level = 4'($urandom_range(0, 15));
        for (int k = 0; k <= PER * len + 2; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            vectors++;
            if (leds !== exp_leds(k, len) || mem_addr !== exp_addr(k, len) ||
                blinker_done !== exp_done(k, len)) begin
                miscompares++;
                $display("FAIL %s k=%0d leds=%b want %b addr=%0d want %0d done=%b want %b",
                         tag, k, leds, exp_leds(k, len), mem_addr, exp_addr(k, len),
                         blinker_done, exp_done(k, len));
            end
        end
        on_blinker = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (blinker_done !== 1'b0 || leds !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s_release done=%b want 0 leds=%b want 0000", tag, blinker_done, leds);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; on_blinker = 1'b0; level = 4'd0;
        #2;
        vectors++;
        if (leds !== 4'b0000 || mem_addr !== 4'd0 || blinker_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset leds=%b addr=%0d done=%b want 0000/0/0", leds, mem_addr, blinker_done);
        end
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();   fill_fixed(); run_playback("level1", 1); endtask
    task automatic test_four();     fill_fixed(); run_playback("level4", 4); endtask
    task automatic test_zero();     fill_fixed(); run_playback("level0", 0); endtask
    task automatic test_clamp();    fill_random(); run_playback("clamp15", 15); endtask

    task automatic test_abort();
        fill_fixed();
        level = 4'd4; on_blinker = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= PER + 3; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (leds !== exp_leds(k, 4) || blinker_done !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_pre k=%0d leds=%b want %b done=%b", k, leds, exp_leds(k, 4), blinker_done);
            end
        end
        on_blinker = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (leds !== 4'b0000 || blinker_done !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_post c=%0d leds=%b want 0000 done=%b want 0", k, leds, blinker_done);
            end
        end
        run_playback("abort_restart", 1);
    endtask

    task automatic test_async_reset();
        int phase [3] = '{3, 5, 7};
        fill_fixed();
        for (int p = 0; p < 3; p++) begin
            level = 4'd1; on_blinker = 1'b1;
            @(posedge clk); #1;
            repeat (phase[p]) begin @(posedge clk); #1; end
            vectors++;
            if (leds !== exp_leds(phase[p], 1) || blinker_done !== exp_done(phase[p], 1)) begin
                miscompares++;
                $display("FAIL areset_pre k=%0d leds=%b want %b done=%b want %b", phase[p],
                         leds, exp_leds(phase[p], 1), blinker_done, exp_done(phase[p], 1));
            end
            #2 reset = 1'b0;
            #1;
            vectors++;
            if (leds !== 4'b0000 || blinker_done !== 1'b0 || mem_addr !== 4'd0) begin
                miscompares++;
                $display("FAIL areset_now k=%0d leds=%b done=%b addr=%0d want 0000/0/0",
                         phase[p], leds, blinker_done, mem_addr);
            end
            on_blinker = 1'b0;
            @(posedge clk); #3 reset = 1'b1;
            repeat (3) begin
                @(posedge clk); #1;
                vectors++;
                if (leds !== 4'b0000 || blinker_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL areset_idle k=%0d leds=%b done=%b want 0000/0", phase[p], leds, blinker_done);
                end
            end
            run_playback("areset_restart", 1);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            fill_random();
            run_playback("random", $urandom_range(0, 15));
        end
    endtask

    initial begin
        on_blinker = 1'b0;
        level      = 4'd0;
        fill_fixed();
        test_reset();
        test_single();
        test_four();
        test_zero();
        test_abort();
        test_clamp();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
